// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handoff,
// execute-stage redirect and the sticky misalignment flag.
interface fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misaligned;

    modport master (
        output imem_req_valid, imem_req_addr,
        output dec_valid, dec_pc, dec_instr,
        output misaligned,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  dec_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  dec_valid, dec_pc, dec_instr,
        input  misaligned,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output dec_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32 instruction fetch: owns the PC, keeps one imem request outstanding and
// hands {pc, instr} to decode; execute-stage redirects flush in-flight work.
//
//   state | meaning
//   REQ   | request for pc presented to imem, waiting for acceptance
//   WAIT  | request accepted, waiting for the response (kill = drop it)
//   HOLD  | instruction held for decode until dec_ready
//   HALT  | misaligned redirect seen; idle until reset
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        dec_valid_q, dec_valid_d;
    logic [31:0] dec_pc_q, dec_pc_d;
    logic [31:0] dec_instr_q, dec_instr_d;
    logic        mis_q, mis_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_pc_q    <= 32'h0;
            dec_instr_q <= 32'h0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            dec_valid_q <= dec_valid_d;
            dec_pc_q    <= dec_pc_d;
            dec_instr_q <= dec_instr_d;
            mis_q       <= mis_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        dec_valid_d = dec_valid_q;
        dec_pc_d    = dec_pc_q;
        dec_instr_d = dec_instr_q;
        mis_d       = mis_q;

        // HALT is left only through reset, so redirects are ignored there
        if (bus.redirect && state_q != HALT) begin
            pc_d        = bus.redirect_pc;
            dec_valid_d = 1'b0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                mis_d   = 1'b1;
                kill_d  = 1'b0;
                state_d = HALT;
            end else begin
                case (state_q)
                    REQ: begin
                        if (bus.imem_req_ready) begin
                            kill_d  = 1'b1;
                            state_d = WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.imem_resp_valid) begin
                            kill_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            kill_d = 1'b1;
                        end
                    end
                    HOLD:    state_d = REQ;
                    default: ;
                endcase
            end
        end else begin
            case (state_q)
                REQ: begin
                    if (bus.imem_req_ready) state_d = WAIT;
                end
                WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            dec_pc_d    = pc_q;
                            dec_instr_d = bus.imem_resp_data;
                            dec_valid_d = 1'b1;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (dec_valid_q && bus.dec_ready) begin
                        dec_valid_d = 1'b0;
                        pc_d        = pc_q + 32'd4;
                        state_d     = REQ;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_req_valid = (state_q == REQ) && !rst;
    assign bus.imem_req_addr  = pc_q;
    assign bus.dec_valid      = dec_valid_q;
    assign bus.dec_pc         = dec_pc_q;
    assign bus.dec_instr      = dec_instr_q;
    assign bus.misaligned     = mis_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model of program order (expected next
// PC, memory contents as a function of address) under directed and random traffic.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_if bus();
    fetch_unit #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // stimulus knobs
    int ready_pct, dready_pct, redir_pct, lat_min, lat_max;
    // reference model
    logic [31:0] exp_pc;
    bit          halted;
    bit          pend;
    logic [31:0] pend_addr;
    int          due, cyc, hs_count, last_hs_cyc;
    logic [31:0] last_hs_pc;
    bit          force_redir;
    logic [31:0] force_pc;
    bit          prev_hold, prev_reqw;
    logic [31:0] prev_dpc, prev_dinstr, prev_addr;

    task automatic step();
        int lat;
        @(negedge clk);
        cyc++;
        if (prev_hold) begin
            chk("dec_hold_valid", 32'(bus.dec_valid), 32'd1);
            chk("dec_hold_pc", bus.dec_pc, prev_dpc);
            chk("dec_hold_instr", bus.dec_instr, prev_dinstr);
        end
        if (prev_reqw) begin
            chk("req_hold_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("req_hold_addr", bus.imem_req_addr, prev_addr);
        end
        chk("misaligned", 32'(bus.misaligned), 32'(halted));
        if (halted) begin
            chk("halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
            chk("halt_dec_valid", 32'(bus.dec_valid), 32'd0);
        end
        if (bus.imem_req_valid) chk("one_outstanding", 32'(pend), 32'd0);

        bus.imem_req_ready  = ($urandom_range(99) < ready_pct);
        bus.dec_ready       = ($urandom_range(99) < dready_pct);
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = $urandom();
        if (pend && cyc == due) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = memf(pend_addr);
            pend = 1'b0;
        end
        bus.redirect    = 1'b0;
        bus.redirect_pc = $urandom();
        if (!halted) begin
            if (force_redir) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = force_pc;
            end else if ($urandom_range(99) < redir_pct) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = $urandom() & 32'hFFFF_FFFC;
            end
        end
        force_redir = 1'b0;

        // what the coming rising edge does, in program-order terms
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("req_addr", bus.imem_req_addr, exp_pc);
            lat       = int'($urandom_range(lat_max, lat_min));
            pend      = 1'b1;
            pend_addr = bus.imem_req_addr;
            due       = cyc + lat;
        end
        prev_hold   = bus.dec_valid && !bus.dec_ready && !bus.redirect;
        prev_dpc    = bus.dec_pc;
        prev_dinstr = bus.dec_instr;
        prev_reqw   = bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect;
        prev_addr   = bus.imem_req_addr;
        if (bus.redirect) begin
            if (bus.redirect_pc[1:0] != 2'b00) halted = 1'b1;
            else exp_pc = bus.redirect_pc;
        end else if (bus.dec_valid && bus.dec_ready) begin
            chk("dec_pc", bus.dec_pc, exp_pc);
            chk("dec_instr", bus.dec_instr, memf(exp_pc));
            hs_count++;
            last_hs_cyc = cyc;
            last_hs_pc  = bus.dec_pc;
            exp_pc      = exp_pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst                 = 1'b1;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.dec_ready       = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_pc     = 32'h0;
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, RST_PC);
        chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst_dec_pc", bus.dec_pc, 32'h0);
        chk("rst_dec_instr", bus.dec_instr, 32'h0);
        chk("rst_misaligned", 32'(bus.misaligned), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        pend        = 1'b0;
        halted      = 1'b0;
        exp_pc      = RST_PC;
        prev_hold   = 1'b0;
        prev_reqw   = 1'b0;
        force_redir = 1'b0;
    endtask

    task automatic wait_hs(input string tag, input int budget);
        int h0 = hs_count;
        for (int i = 0; i < budget && hs_count == h0; i++) step();
        chk({tag, "_progress"}, 32'(hs_count != h0), 32'd1);
    endtask

    task automatic redirect_next(input logic [31:0] pc);
        force_redir = 1'b1;
        force_pc    = pc;
        step();
    endtask

    task automatic knobs(input int rp, input int dp, input int rd, input int lmin, input int lmax);
        ready_pct  = rp;
        dready_pct = dp;
        redir_pct  = rd;
        lat_min    = lmin;
        lat_max    = lmax;
    endtask

    initial begin
        int t0, h0;
        rst = 1'b1;
        cyc = 0; hs_count = 0; last_hs_cyc = 0; last_hs_pc = 32'h0;
        knobs(100, 100, 0, 1, 1);
        do_reset();

        // back-to-back fetch with zero-wait memory
        wait_hs("first", 20);
        chk("first_pc", last_hs_pc, 32'h100);
        t0 = last_hs_cyc;
        wait_hs("second", 20);
        chk("second_pc", last_hs_pc, 32'h104);
        chk("lat_second", 32'(last_hs_cyc - t0), 32'd3);
        t0 = last_hs_cyc;
        wait_hs("third", 20);
        chk("third_pc", last_hs_pc, 32'h108);
        chk("lat_third", 32'(last_hs_cyc - t0), 32'd3);

        // memory stall, then decode stall
        ready_pct = 0;
        repeat (4) step();
        ready_pct  = 100;
        dready_pct = 0;
        repeat (8) step();
        dready_pct = 100;
        wait_hs("backpressure", 20);
        chk("backpressure_pc", last_hs_pc, 32'h10C);

        // redirect in WAIT; stale response arrives two cycles later
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !pend; i++) step();
        redirect_next(32'h200);
        lat_min = 1; lat_max = 1;
        wait_hs("redir_wait", 30);
        chk("redir_wait_pc", last_hs_pc, 32'h200);

        // redirect coinciding with the response
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 20 && !pend; i++) step();
        step();
        redirect_next(32'h300);
        lat_min = 1; lat_max = 1;
        wait_hs("redir_resp", 30);
        chk("redir_resp_pc", last_hs_pc, 32'h300);

        // redirect coinciding with request acceptance
        redirect_next(32'h300);
        wait_hs("redir_req", 30);
        chk("redir_req_pc", last_hs_pc, 32'h300);

        // PC wraps modulo 2^32
        redirect_next(32'hFFFF_FFFC);
        wait_hs("wrap_top", 30);
        chk("wrap_top_pc", last_hs_pc, 32'hFFFF_FFFC);
        wait_hs("wrap_zero", 30);
        chk("wrap_zero_pc", last_hs_pc, 32'h0);

        // random traffic with redirects
        knobs(70, 70, 4, 1, 4);
        h0 = hs_count;
        repeat (3000) step();
        chk("rand_progress", 32'(hs_count - h0 > 100), 32'd1);

        // reset in the middle of traffic
        do_reset();
        h0 = hs_count;
        repeat (800) step();
        chk("rand2_progress", 32'(hs_count - h0 > 20), 32'd1);

        // misaligned target halts fetch until reset
        knobs(100, 100, 0, 1, 1);
        redirect_next(32'h202);
        repeat (20) step();
        chk("mis_sticky", 32'(bus.misaligned), 32'd1);
        do_reset();
        wait_hs("after_halt", 20);
        chk("after_halt_pc", last_hs_pc, 32'h100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
